// File: rtl/core_seq_ctrl_if.sv
// Handshake and status bundle between the core sequencer and its IFU, LSU,
// decoder and CSR/simulator taps.
interface core_seq_ctrl_if #(
   parameter int unsigned CNT_W = 64
);
   logic             ifu_req;
   logic             ifu_done;
   logic [1:0]       ifu_resp;
   logic             dec_ren;
   logic             dec_wen;
   logic             dec_ebreak;
   logic             lsu_req;
   logic             lsu_done;
   logic [1:0]       lsu_resp;
   logic             rf_we;
   logic             pc_we;
   logic             halted;
   logic             bus_err;
   logic [2:0]       state;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   modport master (
      output ifu_req, lsu_req, rf_we, pc_we, halted, bus_err, state, cycle_cnt, instret_cnt,
      input  ifu_done, ifu_resp, dec_ren, dec_wen, dec_ebreak, lsu_done, lsu_resp
   );

   modport slave (
      input  ifu_req, lsu_req, rf_we, pc_we, halted, bus_err, state, cycle_cnt, instret_cnt,
      output ifu_done, ifu_resp, dec_ren, dec_wen, dec_ebreak, lsu_done, lsu_resp
   );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/exec/mem/writeback sequencer with halt/error stop and
// cycle / retired-instruction counters.
module core_seq_ctrl #(
   parameter int unsigned CNT_W = 64
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   core_seq_ctrl_if.master io_bus
);

   typedef enum logic [2:0] {
      StBoot  = 3'd0,
      StFetch = 3'd1,
      StExec  = 3'd2,
      StMem   = 3'd3,
      StWb    = 3'd4,
      StHalt  = 3'd5,
      StError = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_t           r_state;
   state_t           w_next;
   logic             r_ifu_req;
   logic             r_lsu_req;
   logic             r_rf_we;
   logic             r_pc_we;
   logic             r_halted;
   logic             r_bus_err;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instret_cnt;
   logic             w_retire;
   logic             w_running;

   // Done pulses only matter in the state that owns the matching request.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         StBoot:  w_next = StFetch;
         StFetch: begin
            if (io_bus.ifu_done) begin
               w_next = (io_bus.ifu_resp != 2'b00) ? StError : StExec;
            end
         end
         StExec: begin
            if (io_bus.dec_ebreak) begin
               w_next = StHalt;
            end else if (io_bus.dec_ren || io_bus.dec_wen) begin
               w_next = StMem;
            end else begin
               w_next = StWb;
            end
         end
         StMem: begin
            if (io_bus.lsu_done) begin
               w_next = (io_bus.lsu_resp != 2'b00) ? StError : StWb;
            end
         end
         StWb:    w_next = StFetch;
         StHalt:  w_next = StHalt;
         StError: w_next = StError;
         default: w_next = StError;
      endcase
   end

   assign w_retire  = (r_state == StWb) || ((r_state == StExec) && io_bus.dec_ebreak);
   assign w_running = (r_state != StHalt) && (r_state != StError);

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= StBoot;
         r_ifu_req     <= 1'b0;
         r_lsu_req     <= 1'b0;
         r_rf_we       <= 1'b0;
         r_pc_we       <= 1'b0;
         r_halted      <= 1'b0;
         r_bus_err     <= 1'b0;
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         r_state   <= w_next;
         r_ifu_req <= (w_next == StFetch);
         r_lsu_req <= (w_next == StMem);
         r_rf_we   <= (w_next == StWb);
         r_pc_we   <= (w_next == StWb);
         r_halted  <= (w_next == StHalt) || (w_next == StError);
         r_bus_err <= (w_next == StError);
         if (w_running) begin
            r_cycle_cnt <= r_cycle_cnt + CntOne;
         end
         if (w_retire) begin
            r_instret_cnt <= r_instret_cnt + CntOne;
         end
      end
   end

   assign io_bus.ifu_req     = r_ifu_req;
   assign io_bus.lsu_req     = r_lsu_req;
   assign io_bus.rf_we       = r_rf_we;
   assign io_bus.pc_we       = r_pc_we;
   assign io_bus.halted      = r_halted;
   assign io_bus.bus_err     = r_bus_err;
   assign io_bus.state       = r_state;
   assign io_bus.cycle_cnt   = r_cycle_cnt;
   assign io_bus.instret_cnt = r_instret_cnt;

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue core. It steps each instruction through fetch, execute, memory and writeback by handshaking with the IFU and LSU, and it generates the register-file and PC write strobes. It also stops the core on ebreak or a bus error, and keeps cycle and retired-instruction counters for the CSR unit and the simulator.

Parameters:
CNT_W, 64, width of cycle_cnt and instret_cnt (wraps modulo 2^CNT_W)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
ifu_req  out  1  fetch request, level, held until ifu_done
ifu_done  in  1  fetch complete (1-cycle pulse from IFU R-channel handshake)
ifu_resp  in  2  AXI resp of fetch; 2'b00 = OKAY
dec_ren  in  1  decoded instruction is a load
dec_wen  in  1  decoded instruction is a store
dec_ebreak  in  1  decoded instruction is ebreak
lsu_req  out  1  memory request, level, held until lsu_done
lsu_done  in  1  load/store complete (1-cycle pulse)
lsu_resp  in  2  AXI resp of load/store
rf_we  out  1  writeback strobe; ANDed externally with decoder reg_write_en/csreg_write_en
pc_we  out  1  PC register load strobe
halted  out  1  core stopped (ebreak or error)
bus_err  out  1  stopped due to non-OKAY response
state  out  3  current FSM state (debug)
cycle_cnt  out  CNT_W  cycles since reset while running
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT. All outputs 0, both counters 0. Any in-flight request is dropped. Done pulses arriving while rst=0 are ignored.
- States and encodings: BOOT=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6. All outputs are registered or decoded from state only (Moore machine).
- BOOT: lasts 1 cycle, then goes to FETCH. ifu_req=0.
- FETCH: ifu_req=1. On ifu_done:
  - ifu_resp!=0 → ERROR.
  - otherwise → EXEC.
  - Without ifu_done, stay in FETCH with no timeout.
- EXEC: 1 cycle, in which decode and ALU outputs settle.
  - dec_ebreak → HALT; the instruction is retired (instret+1) and there is no rf_we.
  - else dec_ren|dec_wen → MEM. If both are set, it is still one MEM pass.
  - else → WB.
- MEM: lsu_req=1 until lsu_done.
  - lsu_resp!=0 → ERROR, with no writeback and no pc_we.
  - otherwise → WB.
- WB: 1 cycle. rf_we=1, pc_we=1, instret_cnt+1 (also for stores), then → FETCH.
- HALT: absorbing until reset. halted=1, bus_err=0. All requests and strobes are 0.
- ERROR: absorbing until reset. halted=1, bus_err=1. The failed instruction does not retire.
- Latency:
  - ifu_done in the first FETCH cycle: non-memory instruction takes 3 cycles; memory instruction takes 4 cycles plus LSU latency.
  - First ifu_req rises 1 cycle after reset deassertion (BOOT cycle).
- Stray done pulses: ifu_done outside FETCH and lsu_done outside MEM are ignored, with no state or counter change. Done pulses are sampled only while the matching req=1.
- Counters:
  - cycle_cnt increments every cycle in BOOT..WB and freezes in HALT/ERROR.
  - Both counters wrap from all-ones to 0 without any flag.
  - In the same cycle as reset deassertion the counters stay 0.
- rf_we and pc_we are exactly 1-cycle pulses, once per retired non-ebreak instruction.

Test Plan:
- ALU stream: ifu_done/resp=0 every FETCH cycle, dec_*=0, 10 instructions → rf_we/pc_we pulse every 3rd cycle starting cycle 3 after reset release; instret_cnt=10, cycle_cnt=31 at the 10th WB+1.
- Load with LSU latency 5 → lsu_req high exactly 5 cycles; WB follows lsu_done by 1 cycle; ren&wen both set gives a single MEM pass.
- Fetch error: ifu_resp=2'b10 on ifu_done → next state ERROR; halted=1, bus_err=1; no rf_we; instret unchanged; cycle_cnt frozen for 20 further cycles.
- ebreak after 4 instructions → HALT; instret_cnt=5, halted=1, bus_err=0; later ifu_done/lsu_done pulses cause no change.
- Stray pulses: lsu_done in FETCH and ifu_done in MEM → ignored; the state sequence is identical to a run without the pulses.
- Reset mid-MEM: drive rst=0 asynchronously between clock edges → lsu_req, counters and state go to 0 immediately; after release, BOOT 1 cycle then FETCH. With CNT_W=4, 16 cycles → cycle_cnt wraps to 0.
